// File: rtl/rnn_pkg.sv
// Shared constants and types for the denoise RNN datapath.
package rnn_pkg;

   localparam int FLOAT = 32;
   localparam int NFEAT = 42;
   localparam int NGAIN = 22;
   localparam int IDXW  = $clog2(NFEAT);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } bank_state_e;

endpackage

// File: rtl/rnn_feature_packer_if.sv
// Word stream in, packed frame out, for the RNN feature packer.
interface rnn_feature_packer_if;
   import rnn_pkg::*;

   logic [FLOAT-1:0]       in_data;
   logic                   in_valid;
   logic                   in_last;
   logic                   in_ready;
   logic [NFEAT*FLOAT-1:0] feature;
   logic                   feat_valid;
   logic                   feat_ready;

   modport master (
      output in_data, in_valid, in_last, feat_ready,
      input  in_ready, feature, feat_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, feat_ready,
      output in_ready, feature, feat_valid
   );

endinterface

// File: rtl/feature_bank.sv
// One frame of feature words with a single write port and flat readout.
module feature_bank
   import rnn_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [IDXW-1:0]        waddr,
   input  logic [FLOAT-1:0]       wdata,
   output logic [NFEAT*FLOAT-1:0] data
);

   logic [FLOAT-1:0] mem_q [NFEAT];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NFEAT; i++) begin
         if (rst) begin
            mem_q[i] <= '0;
         end else if (we && waddr == IDXW'(i)) begin
            mem_q[i] <= wdata;
         end
      end
   end

   always_comb begin
      data = '0;
      for (int i = 0; i < NFEAT; i++) begin
         data[i*FLOAT +: FLOAT] = mem_q[i];
      end
   end

endmodule

// File: rtl/rnn_feature_packer.sv
// Double-buffered packer: word stream into full frames for the RNN core.
module rnn_feature_packer
   import rnn_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   rnn_feature_packer_if.slave  bus,
   output logic                 frame_err
);

   bank_state_e state_q [2];
   bank_state_e state_d [2];
   logic        wr_sel_q, wr_sel_d;
   logic        rd_sel_q, rd_sel_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic        err_q, err_d;

   logic                   in_rdy;
   logic                   accept;
   logic                   take;
   logic                   at_end;
   logic [1:0]             we;
   logic [NFEAT*FLOAT-1:0] bank_data [2];

   assign in_rdy = (state_q[wr_sel_q] != FULL) && !rst;
   assign accept = bus.in_valid && in_rdy;
   assign take   = (state_q[rd_sel_q] == FULL) && bus.feat_ready;
   assign at_end = (idx_q == IDXW'(NFEAT-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q[0] <= EMPTY;
         state_q[1] <= EMPTY;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         idx_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
      end
   end

   // Read and write sides never target the same bank in one cycle.
   always_comb begin
      state_d  = state_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      idx_d    = idx_q;
      err_d    = 1'b0;
      if (take) begin
         state_d[rd_sel_q] = EMPTY;
         rd_sel_d          = ~rd_sel_q;
      end
      if (accept) begin
         unique case (1'b1)
            (!at_end && !bus.in_last): begin
               state_d[wr_sel_q] = FILL;
               idx_d             = idx_q + IDXW'(1);
            end
            (at_end && bus.in_last): begin
               state_d[wr_sel_q] = FULL;
               wr_sel_d          = ~wr_sel_q;
               idx_d             = '0;
            end
            default: begin
               state_d[wr_sel_q] = EMPTY;
               idx_d             = '0;
               err_d             = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      we             = '0;
      we[wr_sel_q]   = accept;
      bus.in_ready   = in_rdy;
      bus.feat_valid = (state_q[rd_sel_q] == FULL);
      bus.feature    = rd_sel_q ? bank_data[1] : bank_data[0];
      frame_err      = err_q;
   end

   feature_bank u_bank0 (
      .clk   (clk),
      .rst   (rst),
      .we    (we[0]),
      .waddr (idx_q),
      .wdata (bus.in_data),
      .data  (bank_data[0])
   );

   feature_bank u_bank1 (
      .clk   (clk),
      .rst   (rst),
      .we    (we[1]),
      .waddr (idx_q),
      .wdata (bus.in_data),
      .data  (bank_data[1])
   );

endmodule
